// File: rtl/program_loader.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// program_loader
//
// Streams a program image into the CPU instruction memory over a valid/ready
// handshake, one word per accepted beat. The CPU is held in reset for the
// whole load and released only after the final word has been written.
//
// Build option: define LOADER_CHECKSUM_EN to add a trailing checksum beat.
// The sum of all loaded words, modulo 2^DATA_WIDTH, is compared against it.
// A mismatch parks the loader in ERROR with the CPU still held in reset.
//
// Ports
//   clock       single clock, rising edge
//   reset       asynchronous, active-low; forces every output to its reset value
//   load_start  one-cycle request to begin a load (honoured in IDLE/RUN/ERROR)
//   load_len    word count minus one, sampled with load_start
//   in_valid    in_data carries a word
//   in_data     instruction word (or checksum in CHECK)
//   in_ready    loader accepts a beat this cycle
//   mem_we      instruction memory write enable, one cycle per word
//   mem_addr    write address
//   mem_wdata   write data
//   cpu_reset   active-high reset to the CPU
//   busy        a load is in progress
//   done        load completed and the CPU is running
//   error       checksum mismatch (always 0 without LOADER_CHECKSUM_EN)
// ---------------------------------------------------------------------------
module program_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic [ADDR_WIDTH-1:0] load_len,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_FLUSH = 3'd2,
`ifdef LOADER_CHECKSUM_EN
    ST_CHECK = 3'd4,
    ST_ERROR = 3'd5,
`endif
    ST_RUN   = 3'd3
  } state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] ptr_reg, ptr_next;
  logic [ADDR_WIDTH-1:0] len_reg, len_next;
  logic                  mem_we_reg, mem_we_next;
  logic [ADDR_WIDTH-1:0] mem_addr_reg, mem_addr_next;
  logic [DATA_WIDTH-1:0] mem_wdata_reg, mem_wdata_next;
  logic                  start_load;
`ifdef LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum_reg, sum_next;
`endif

  // Next-state and Moore outputs. Status outputs decode the state register
  // directly, so an asynchronous reset forces them at once.
  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    len_next       = len_reg;
    mem_we_next    = 1'b0;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
`ifdef LOADER_CHECKSUM_EN
    sum_next       = sum_reg;
`endif
    start_load     = 1'b0;
    in_ready       = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    cpu_reset      = 1'b1;
    error          = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        start_load = load_start;
      end

      ST_LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          mem_we_next    = 1'b1;
          mem_addr_next  = ptr_reg;
          mem_wdata_next = in_data;
`ifdef LOADER_CHECKSUM_EN
          sum_next       = sum_reg + in_data;
`endif
          // The last beat leaves LOAD without bumping the pointer, so a
          // full-depth image never wraps back to address 0.
          if (ptr_reg == len_reg) begin
`ifdef LOADER_CHECKSUM_EN
            state_next = ST_CHECK;
`else
            state_next = ST_FLUSH;
`endif
          end else begin
            ptr_next = ptr_reg + ADDR_ONE;
          end
        end
      end

      // Gives the final memory write its cycle before the CPU is released.
      ST_FLUSH: begin
        busy       = 1'b1;
        state_next = ST_RUN;
      end

      ST_RUN: begin
        cpu_reset  = 1'b0;
        done       = 1'b1;
        start_load = load_start;
      end

`ifdef LOADER_CHECKSUM_EN
      // The checksum beat is consumed here and never written to memory.
      ST_CHECK: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          state_next = (in_data == sum_reg) ? ST_RUN : ST_ERROR;
        end
      end

      ST_ERROR: begin
        error      = 1'b1;
        start_load = load_start;
      end
`endif

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    if (start_load) begin
      state_next = ST_LOAD;
      len_next   = load_len;
      ptr_next   = '0;
`ifdef LOADER_CHECKSUM_EN
      sum_next   = '0;
`endif
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      ptr_reg       <= '0;
      len_reg       <= '0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum_reg       <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      len_reg       <= len_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
`ifdef LOADER_CHECKSUM_EN
      sum_reg       <= sum_next;
`endif
    end
  end

  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;

endmodule

// File: doc/program_loader.md
# program_loader

Streams a program image into the instruction memory over a valid/ready handshake, writing one instruction word per accepted beat. It holds the CPU in reset for the whole load and releases it only after the final word is written. It sits between the test/host side and the CPU's instruction memory write port. It drives the CPU's active-high `reset` input.

## Interface
- `DATA_WIDTH`, 16: instruction word width.
- `ADDR_WIDTH`, 8: instruction memory address width; depth = 2^ADDR_WIDTH words.
- `clock` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-low; asserting it immediately forces every output to its reset value.
- `load_start` in 1: one-cycle request to begin a load.
- `load_len` in ADDR_WIDTH: word count minus one; sampled with `load_start`.
- `in_valid` in 1: `in_data` holds a valid word.
- `in_data` in DATA_WIDTH: instruction word.
- `in_ready` out 1: loader accepts a beat this cycle.
- `mem_we` out 1: instruction memory write enable; one cycle per word.
- `mem_addr` out ADDR_WIDTH: write address.
- `mem_wdata` out DATA_WIDTH: write data.
- `cpu_reset` out 1: active-high reset to the CPU.
- `busy` out 1: a load is in progress.
- `done` out 1: the load completed and the CPU is running.
- `error` out 1: checksum mismatch (checksum build only).

## Operation
- Reset values: `cpu_reset`=1, `in_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, `done`=0, `error`=0, state IDLE, word pointer 0.
- A beat is accepted on a cycle where `in_valid && in_ready`.
- **IDLE**: `cpu_reset`=1. `load_start` moves the state to LOAD, captures `load_len`, clears the pointer and checksum, and clears `done`/`error`.
- **LOAD**: `in_ready`=1 and `busy`=1.
  - Each accepted beat writes `in_data` to address = pointer, then increments the pointer.
  - The beat where pointer == captured `load_len` is the last one. After it, the state goes to FLUSH, or to CHECK in the checksum build.
  - `load_start` is ignored in LOAD.
- **FLUSH**: one cycle with `in_ready`=0, then RUN.
- **RUN**: `cpu_reset`=0, `done`=1, `busy`=0, `in_ready`=0.
  - `load_start` in RUN returns the state to LOAD.
  - `cpu_reset` rises on the next edge.
  - `done` clears on the same edge.
- **ERROR** (checksum build only): `cpu_reset`=1, `error`=1, `in_ready`=0. Only `load_start` or `reset` leaves ERROR.
- Pointer never wraps. With `load_len` = 2^ADDR_WIDTH−1, the last write is to the top address and the state exits LOAD without incrementing past it.
- Gaps in `in_valid` produce no writes and leave the pointer unchanged.

## Timing
- Beat accepted at edge N → `mem_we`=1 with that address/data during cycle N+1. `mem_we` is registered and lasts exactly one cycle.
- Consecutive beats give back-to-back writes at throughput 1 word/cycle.
- Last beat accepted at edge N (non-checksum build):
  - FLUSH during cycle N+1, carrying the final write.
  - `cpu_reset`=0 and `done`=1 from edge N+2.
- `load_start` at edge S → `in_ready`=1 from edge S+1.
- `load_start` while in RUN → `cpu_reset`=1 from edge S+1.
- `reset` asserted mid-load: partially loaded words stay in memory, the pointer returns to 0, and the next load starts at address 0.

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - A running sum of all loaded words, modulo 2^DATA_WIDTH, is kept.
  - After the last data beat the state goes to CHECK (`in_ready`=1, no memory write).
  - The CHECK beat accepted at edge M is compared with the sum. Match → RUN from edge M+1 with `cpu_reset`=0. Mismatch → ERROR from edge M+1.
- `LOADER_CHECKSUM_EN` undefined:
  - No CHECK or ERROR state.
  - `error` is tied to 0.
  - LOAD → FLUSH → RUN as above.

## Test plan
- **Reset**: hold `reset`=0 for 3 cycles → `cpu_reset`=1; `in_ready`, `mem_we`, `busy`, `done`, `error` = 0; `mem_addr`=0.
- **Basic load**: `load_len`=2, continuous beats 0x1234, 0x5678, 0x9ABC.
  - Writes (0,0x1234), (1,0x5678), (2,0x9ABC) on three consecutive cycles.
  - `cpu_reset` falls and `done` rises 2 cycles after the last beat.
- **Backpressure**: same image with `in_valid` low every other cycle → identical writes, no write in gap cycles, addresses still 0,1,2.
- **Full depth**: `load_len`=255, words = address value → 256 writes to addresses 0..255, last write to 255, then RUN with no extra write.
- **Mid-operation events**:
  - `reset` pulsed low after 2 beats of a 4-word load → reset values restored. A fresh 1-word load (`load_len`=0, 0xBEEF) then writes (0,0xBEEF).
  - `load_start` in RUN → `cpu_reset`=1 on the next cycle.
- **Checksum** (with `LOADER_CHECKSUM_EN`): words 0x0001, 0x0002, 0xFFFF.
  - Checksum 0x0002 → RUN, `cpu_reset`=0.
  - Checksum 0x0003 → `error`=1, `cpu_reset` stays 1.
